// File: rtl/img_proc_engine_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : img_proc_engine_if
// Brief    : Job handshake plus source-read / destination-write bus of the engine.
// Revision : 1.0
// ============================================================================
interface img_proc_engine_if #(
    parameter int COORD_W = 6,
    parameter int CH_W    = 8
);
    logic                 start;
    logic [1:0]           mode;
    logic [3*CH_W-1:0]    in_pix;
    logic [COORD_W-1:0]   rd_row;
    logic [COORD_W-1:0]   rd_col;
    logic [COORD_W-1:0]   wr_row;
    logic [COORD_W-1:0]   wr_col;
    logic                 out_we;
    logic [3*CH_W-1:0]    out_pix;
    logic                 busy;
    logic                 done;

    // master: job issuer and source memory; slave: the engine
    modport master (
        output start, mode, in_pix,
        input  rd_row, rd_col, wr_row, wr_col, out_we, out_pix, busy, done
    );
    modport slave (
        input  start, mode, in_pix,
        output rd_row, rd_col, wr_row, wr_col, out_we, out_pix, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/img_proc_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : img_proc_engine
// Brief    : Source-to-destination image engine: V/H mirror, grayscale, 3x3 sharpen.
// Revision : 1.0
// ============================================================================
module img_proc_engine #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int COORD_W = 6,
    parameter int CH_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    img_proc_engine_if.slave   bus
);
    localparam int PIX_W = 3 * CH_W;
    localparam int ACC_W = CH_W + 5;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [1:0] MODE_MIRROR_V = 2'd0;
    localparam logic [1:0] MODE_MIRROR_H = 2'd1;
    localparam logic [1:0] MODE_GRAY     = 2'd2;
    localparam logic [1:0] MODE_SHARPEN  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_PT = 3'd1,
        RUN_SH = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [COORD_W-1:0]        row_q, row_d;
    logic [COORD_W-1:0]        col_q, col_d;
    logic [3:0]                tap_q, tap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [COORD_W-1:0]        wr_row_q, wr_row_d;
    logic [COORD_W-1:0]        wr_col_q, wr_col_d;
    logic                      out_we_q, out_we_d;
    logic [PIX_W-1:0]          out_pix_q, out_pix_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [CH_W-1:0]           in_r, in_g, in_b, ch_max, ch_min, gray_g, sharp_g;
    logic [CH_W:0]             gray_sum;
    logic signed [ACC_W-1:0]   g_ext, acc_next;
    logic                      last_col, last_row, last_pix;
    logic [COORD_W-1:0]        next_row, next_col;
    logic                      tap_up, tap_dn, tap_lf, tap_rt, tap_ok;
    logic [COORD_W-1:0]        sh_row, sh_col, rd_row, rd_col;

    assign in_r = bus.in_pix[PIX_W-1:2*CH_W];
    assign in_g = bus.in_pix[2*CH_W-1:CH_W];
    assign in_b = bus.in_pix[CH_W-1:0];

    always_comb begin
        ch_max = in_r;
        ch_min = in_r;
        if (in_g > ch_max) ch_max = in_g;
        if (in_b > ch_max) ch_max = in_b;
        if (in_g < ch_min) ch_min = in_g;
        if (in_b < ch_min) ch_min = in_b;
    end

    assign gray_sum = {1'b0, ch_max} + {1'b0, ch_min};
    assign gray_g   = gray_sum[CH_W:1];

    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);
    assign last_pix = last_col && last_row;
    assign next_col = last_col ? '0 : col_q + ONE;
    assign next_row = last_col ? row_q + ONE : row_q;

    // Tap order: centre, then the row above, same row, row below (left to right)
    always_comb begin
        tap_up = 1'b0;
        tap_dn = 1'b0;
        tap_lf = 1'b0;
        tap_rt = 1'b0;
        case (tap_q)
            4'd1: begin tap_up = 1'b1; tap_lf = 1'b1; end
            4'd2: begin tap_up = 1'b1; end
            4'd3: begin tap_up = 1'b1; tap_rt = 1'b1; end
            4'd4: begin tap_lf = 1'b1; end
            4'd5: begin tap_rt = 1'b1; end
            4'd6: begin tap_dn = 1'b1; tap_lf = 1'b1; end
            4'd7: begin tap_dn = 1'b1; end
            4'd8: begin tap_dn = 1'b1; tap_rt = 1'b1; end
            default: ;
        endcase
    end

    // Bounds are tested on the unshifted coordinate so nothing ever wraps
    assign tap_ok = !(tap_up && (row_q == '0)) && !(tap_dn && last_row) &&
                    !(tap_lf && (col_q == '0)) && !(tap_rt && last_col);
    assign sh_row = !tap_ok ? row_q : tap_up ? row_q - ONE : tap_dn ? row_q + ONE : row_q;
    assign sh_col = !tap_ok ? col_q : tap_lf ? col_q - ONE : tap_rt ? col_q + ONE : col_q;

    assign g_ext    = $signed({5'b0, in_g});
    assign acc_next = (tap_q == 4'd0) ? (g_ext <<< 3) + g_ext :
                      tap_ok          ? acc_q - g_ext : acc_q;

    always_comb begin
        if (acc_next[ACC_W-1])
            sharp_g = '0;
        else if (|acc_next[ACC_W-2:CH_W])
            sharp_g = '1;
        else
            sharp_g = acc_next[CH_W-1:0];
    end

    always_comb begin
        rd_row = '0;
        rd_col = '0;
        case (state_q)
            RUN_PT: begin
                case (mode_q)
                    MODE_MIRROR_V: begin rd_row = LAST_ROW - row_q; rd_col = col_q; end
                    MODE_MIRROR_H: begin rd_row = row_q; rd_col = LAST_COL - col_q; end
                    default:       begin rd_row = row_q; rd_col = col_q; end
                endcase
            end
            RUN_SH: begin
                rd_row = sh_row;
                rd_col = sh_col;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        row_d     = row_q;
        col_d     = col_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        out_pix_d = out_pix_q;
        out_we_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    row_d   = '0;
                    col_d   = '0;
                    tap_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.mode == MODE_SHARPEN) ? RUN_SH : RUN_PT;
                end
            end
            RUN_PT: begin
                out_we_d  = 1'b1;
                wr_row_d  = row_q;
                wr_col_d  = col_q;
                out_pix_d = (mode_q == MODE_GRAY) ? {{CH_W{1'b0}}, gray_g, {CH_W{1'b0}}}
                                                  : bus.in_pix;
                row_d     = next_row;
                col_d     = next_col;
                if (last_pix) state_d = FLUSH;
            end
            RUN_SH: begin
                acc_d = acc_next;
                if (tap_q == 4'd8) begin
                    tap_d     = '0;
                    out_we_d  = 1'b1;
                    wr_row_d  = row_q;
                    wr_col_d  = col_q;
                    out_pix_d = {{CH_W{1'b0}}, sharp_g, {CH_W{1'b0}}};
                    row_d     = next_row;
                    col_d     = next_col;
                    if (last_pix) state_d = FLUSH;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            out_we_q  <= 1'b0;
            out_pix_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            out_we_q  <= out_we_d;
            out_pix_q <= out_pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rd_row  = rd_row;
    assign bus.rd_col  = rd_col;
    assign bus.wr_row  = wr_row_q;
    assign bus.wr_col  = wr_col_q;
    assign bus.out_we  = out_we_q;
    assign bus.out_pix = out_pix_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_img_proc_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_img_proc_engine
// Brief    : Directed bench for img_proc_engine on a 4x3 image.
// Revision : 1.0
// ============================================================================
module tb_img_proc_engine;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;
    localparam int COORD_W = 2;
    localparam int CH_W    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   c1    = 0;
    int   wcount = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;

    logic [23:0] src [0:15];
    logic [23:0] dst [0:15];
    int          log_idx [0:15];
    int          log_cyc [0:15];

    img_proc_engine_if #(.COORD_W(COORD_W), .CH_W(CH_W)) bus ();

    img_proc_engine #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .COORD_W (COORD_W),
        .CH_W    (CH_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.in_pix = src[{bus.rd_row, bus.rd_col}];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Destination memory model, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.out_we === 1'b1) begin
            dst[{bus.wr_row, bus.wr_col}] = bus.out_pix;
            if (wcount < 16) begin
                log_idx[wcount] = int'({bus.wr_row, bus.wr_col});
                log_cyc[wcount] = cyc - c1;
            end
            wcount = wcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_dst();
        for (int i = 0; i < 16; i++) dst[i] = 24'hEEEEEE;
        wcount = 0;
    endtask

    task automatic load_test_img();
        for (int i = 0; i < 16; i++) src[i] = 24'h0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                src[r*4 + c] = {8'(r), 8'(c), 8'h55};
    endtask

    task automatic load_fill(input logic [23:0] v);
        for (int i = 0; i < 16; i++) src[i] = v;
    endtask

    task automatic run_job(input logic [1:0] m, input int glitch, output int l);
        clear_dst();
        bus.mode  = m;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        c1 = cyc;
        chk("busy_at_c1", {31'd0, bus.busy}, 32'd1);
        l = -1;
        for (int i = 0; i < 300; i++) begin
            if (i == glitch) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                l = cyc - c1;
                break;
            end
            step(1);
        end
        bus.start = 1'b0;
        if (l < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
        step(1);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        load_test_img();
        clear_dst();
        step(3);
        chk("rst_busy",    {31'd0, bus.busy},   32'd0);
        chk("rst_done",    {31'd0, bus.done},   32'd0);
        chk("rst_we",      {31'd0, bus.out_we}, 32'd0);
        chk("rst_pix",     {8'd0, bus.out_pix}, 32'd0);
        chk("rst_rd_addr", {28'd0, bus.rd_row, bus.rd_col}, 32'd0);
        chk("rst_wr_addr", {28'd0, bus.wr_row, bus.wr_col}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Vertical mirror
        run_job(2'd0, -1, lat);
        chk("mv_00",        {8'd0, dst[0]},  32'h020055);
        chk("mv_23",        {8'd0, dst[11]}, 32'h000355);
        chk("mv_writes",    wcount,  32'd12);
        chk("mv_done_lat",  lat,     32'd13);
        chk("mv_first_cyc", log_cyc[0], 32'd1);
        chk("mv_order_5",   log_idx[5], 32'd5);
        chk("mv_order_11",  log_idx[11], 32'd11);

        // Horizontal mirror
        run_job(2'd1, -1, lat);
        chk("mh_10", {8'd0, dst[4]}, 32'h010355);
        chk("mh_13", {8'd0, dst[7]}, 32'h010055);
        chk("mh_done_lat", lat, 32'd13);

        // Grayscale: (200 + 10) >> 1 = 105
        load_fill(24'hC80A64);
        run_job(2'd2, -1, lat);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                chk($sformatf("gray_%0d%0d", r, c), {8'd0, dst[r*4 + c]}, 32'h006900);

        // Sharpen on uniform G=50 (R/B non-zero to prove they are ignored)
        load_fill({8'h11, 8'd50, 8'h22});
        run_job(2'd3, -1, lat);
        chk("sh_00", {8'd0, dst[0]},  32'h00FF00);
        chk("sh_03", {8'd0, dst[3]},  32'h00FF00);
        chk("sh_20", {8'd0, dst[8]},  32'h00FF00);
        chk("sh_23", {8'd0, dst[11]}, 32'h00FF00);
        chk("sh_01", {8'd0, dst[1]},  32'h00C800);
        chk("sh_10", {8'd0, dst[4]},  32'h00C800);
        chk("sh_11", {8'd0, dst[5]},  32'h003200);
        chk("sh_12", {8'd0, dst[6]},  32'h003200);
        chk("sh_writes",   wcount, 32'd12);
        chk("sh_first_cyc", log_cyc[0], 32'd9);
        chk("sh_last_cyc", log_cyc[11], 32'd108);
        chk("sh_done_lat", lat, 32'd109);

        // Sharpen with dark centre: 0 - 8*255 clamps to 0
        load_fill({8'h00, 8'd255, 8'h00});
        src[5] = 24'h000000;
        run_job(2'd3, -1, lat);
        chk("shn_11", {8'd0, dst[5]}, 32'h000000);
        chk("shn_00", {8'd0, dst[0]}, 32'h00FF00);

        // A second start mid-job must be ignored
        load_test_img();
        run_job(2'd0, 3, lat);
        chk("gl_00", {8'd0, dst[0]}, 32'h020055);
        chk("gl_10", {8'd0, dst[4]}, 32'h010055);
        chk("gl_writes",   wcount, 32'd12);
        chk("gl_done_lat", lat, 32'd13);

        // Reset during write 5
        clear_dst();
        bus.mode  = 2'd2;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        c1 = cyc;
        step(6);
        chk("rs_we_write5", {31'd0, bus.out_we}, 32'd1);
        chk("rs_wr_addr5", {28'd0, bus.wr_row, bus.wr_col}, 32'd5);
        rst_n = 1'b0;
        step(1);
        chk("rs_we",      {31'd0, bus.out_we}, 32'd0);
        chk("rs_busy",    {31'd0, bus.busy},   32'd0);
        chk("rs_done",    {31'd0, bus.done},   32'd0);
        chk("rs_pix",     {8'd0, bus.out_pix}, 32'd0);
        chk("rs_wr_addr", {28'd0, bus.wr_row, bus.wr_col}, 32'd0);
        chk("rs_rd_addr", {28'd0, bus.rd_row, bus.rd_col}, 32'd0);
        rst_n = 1'b1;
        step(10);
        chk("rs_no_more_writes", wcount, 32'd6);
        chk("rs_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Normal job after reset
        run_job(2'd1, -1, lat);
        chk("pr_10", {8'd0, dst[4]}, 32'h010355);
        chk("pr_23", {8'd0, dst[11]}, 32'h020055);
        chk("pr_writes",   wcount, 32'd12);
        chk("pr_done_lat", lat, 32'd13);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/img_proc_engine.md
Name: img_proc_engine

Overview:
- Parametrised successor of the fixed 64x64 image processing FSM.
- Reads a source image through a read port and writes a separate destination image through an independent write port, so no operation runs in place.
- Supports four run-time modes per job: vertical mirror, horizontal mirror, grayscale, and 3x3 sharpen.
- Jobs use a start/busy/done handshake. Sits between the source image memory and the destination image memory.

Parameters:
IMG_W, 64, image width in pixels (>=2)
IMG_H, 64, image height in pixels (>=2)
COORD_W, 6, coordinate width; 2^COORD_W >= max(IMG_W, IMG_H)
CH_W, 8, bits per colour channel; pixel = 3*CH_W, packed R[3CH_W-1:2CH_W], G[2CH_W-1:CH_W], B[CH_W-1:0]

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  job request, sampled only in IDLE
mode  in  2  0=MIRROR_V, 1=MIRROR_H, 2=GRAY, 3=SHARPEN; latched with start
in_pix  in  3*CH_W  source pixel at (rd_row, rd_col); combinational read, sampled on the next edge
rd_row, rd_col  out  COORD_W  source read address
wr_row, wr_col  out  COORD_W  destination write address
out_we  out  1  destination write enable
out_pix  out  3*CH_W  destination write data
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. All outputs 0: rd/wr addresses, out_we, out_pix, busy, done.
- Reset has priority over everything. Mid-job reset aborts immediately; no further writes occur.
- States: IDLE, RUN_PT, RUN_SH, FLUSH, DONE.
- IDLE: start=1 latches mode and enters RUN_PT (modes 0-2) or RUN_SH (mode 3); busy=1. start is ignored while busy=1 or done=1.
- Scan order for every mode: destination pixels in raster order, row 0..IMG_H-1, col 0..IMG_W-1 within each row.
- RUN_PT issues one read per cycle. The write for pixel k occurs in the cycle after its read (wr address = pixel k coordinates, out_we=1). This overlaps the read of pixel k+1.
- RUN_PT read addresses:
  - MIRROR_V reads (IMG_H-1-r, c).
  - MIRROR_H reads (r, IMG_W-1-c).
  - GRAY reads (r, c).
- RUN_PT data:
  - Mirror modes write in_pix unchanged.
  - GRAY writes G = (max(R,G,B) + min(R,G,B)) >> 1, computed in CH_W+1 bits, floored. R=B=0.
- RUN_SH spends exactly 9 read cycles per pixel, tap counter 0..8.
  - Tap order (dr,dc): (0,0), (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
  - An out-of-bounds tap drives the centre address and contributes nothing.
- RUN_SH accumulator: signed CH_W+5 bits, using G channel only.
  - Tap 0 loads 9*G.
  - Each in-bounds neighbour subtracts G.
- RUN_SH write: in the cycle after tap 8, out_we=1 and out_pix G = clamp(acc, 0, 2^CH_W-1), R=B=0. This overlaps tap 0 of the next pixel.
- After the last read, FLUSH performs the final write. DONE then holds done=1 and busy=0 for one cycle, returning to IDLE.
- out_we is 0 in every cycle without a write. out_pix and wr address hold their last values when out_we=0.
- Timing, with the first read in cycle c1:
  - RUN_PT writes pixel k in cycle c1+k+1; done is high in c1+IMG_W*IMG_H+1.
  - RUN_SH writes pixel k in cycle c1+9(k+1); done is high in c1+9*IMG_W*IMG_H+1.
  - c1 is the cycle after the start edge.
- Width rules: coordinate arithmetic in COORD_W bits. Neighbour bounds checks are done before offsetting, with no wrap-around.

Test Plan:
1. IMG_W=4, IMG_H=3, source pixel = {R=r, G=c, B=0x55}, mode 0 -> write k=0 at (0,0) data 0x020055; write at (2,3) data 0x000355; exactly 12 writes; done 13 cycles after c1.
2. Same image, mode 1 -> write at (1,0) data 0x010355; write at (1,3) data 0x010055.
3. Mode 2, all pixels 0xC80A64 (R=200, G=10, B=100) -> every out_pix = 0x006900.
4. Mode 3, uniform G=50 on 4x3 -> corners 255 (450-150=300, clamped); edges (0,1) and (1,0) 200; interior (1,1) 50; done at c1+109.
5. Mode 3, centre (1,1) G=0, all others G=255 -> out at (1,1)=0x000000 (negative clamp); corner (0,0)=255.
6. Protocol/reset:
   - start pulsed again mid-job with a different mode -> ignored, output unchanged.
   - rst_n=0 during write 5 -> next cycle out_we=0, busy=0, all outputs 0, no further writes.
   - A new start after reset runs a full job normally.
